fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline: owns the PC, drives the instruction-memory request, and loads the IF/ID pipeline register consumed by decode. It sits directly upstream of the hazard unit. It consumes that unit's `hazard`, `branch` and `jump` outputs, plus the redirect targets computed in decode, to stall, redirect and squash. It also freezes on memory-stage stalls and stops permanently on HALT.

## Interface
Parameters:
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  `imemload` is valid this cycle for `imemaddr`.
- `imemload`  in  32  fetched instruction word.
- `imemREN`  out  1  instruction read request.
- `imemaddr`  out  32  fetch address; equals current PC.
- `hazard`  in  1  decode stall from the hazard unit; hold PC and IF/ID.
- `branch`  in  1  taken branch resolved in decode.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  J/JAL/JR resolved in decode.
- `jump_target`  in  32  jump destination.
- `mem_stall`  in  1  downstream memory stage waiting on dhit; freeze whole stage.
- `halt`  in  1  HALT decoded; stop fetching.
- `id_instr`  out  32  IF/ID instruction; 0 (nop) when bubble.
- `id_npc`  out  32  IF/ID PC+4 of that instruction.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  count of instructions accepted into IF/ID.

## Operation
- States: FETCH, HALTED. Reset -> FETCH. FETCH -> HALTED when `halt`=1 and `mem_stall`=0. HALTED is left only by `nRST`.
- `imemREN`=1 in FETCH and 0 in HALTED. `imemaddr`=pc combinationally.
- Per-edge priority in FETCH, highest first:
  1. `mem_stall`: PC, IF/ID and counter hold; `halt`, `hazard` and redirects ignored.
  2. `halt`: PC holds; IF/ID becomes a bubble; go HALTED.
  3. `hazard`: PC and IF/ID hold; any `ihit` this cycle is discarded and the word is refetched. `branch`/`jump` are ignored.
  4. Redirect (`jump` or `branch`): PC <= `jump_target` if `jump`, else `branch_target`. IF/ID becomes a bubble whether or not `ihit`=1 (wrong-path squash).
  5. `ihit`: PC <= PC+4; IF/ID <= {`imemload`, PC+4, 1}; `fetch_count`++.
  6. Otherwise (miss): PC holds; IF/ID becomes a bubble.
- Bubble = `id_instr` 0, `id_npc` 0, `id_valid` 0.
- In HALTED, PC holds and IF/ID stays a bubble.
- Arithmetic: PC+4 and `fetch_count` wrap modulo 2^32. Bits [1:0] of the loaded PC are forced to 00.

## Timing
- Reset (asynchronous, immediate): pc=`PC_INIT`; `id_instr`=0, `id_npc`=0, `id_valid`=0; `fetch_count`=0; state=FETCH. Hence `imemREN`=1 and `imemaddr`=`PC_INIT` while in reset.
- Fetch-to-decode latency: 1 edge after `ihit`.
- Redirect penalty: 1 bubble. The target address appears on `imemaddr` the cycle after `branch`/`jump`.
- Redirect during a miss abandons the miss; the new address is presented next cycle.
- Reset asserted mid-miss or mid-stall takes effect immediately with no residual state.

## Structure
- Add to `cpu_types_pkg`:
  - `fetch_state_t` enum (FETCH, HALTED);
  - `if_id_t` packed struct {`word_t` instr, `word_t` npc, logic valid};
  - `PC_INIT` default constant.
- One sub-module, `pc_reg`: PC flop with hold, load and increment enables, and asynchronous reset to `PC_INIT`. IF/ID register, next-state logic and counter live in `fetch_unit`.

## Test plan
- Reset then `ihit`=1 for 3 cycles with words A, B, C: `imemaddr` 0, 4, 8. IF/ID shows A/4, B/8, C/12 with `id_valid`=1. `fetch_count`=3.
- `ihit`=0 for 2 cycles at PC 0x10: `imemaddr` holds at 0x10 and `id_valid`=0 both cycles. Then `ihit`=1 with word W gives IF/ID W/0x14.
- `hazard`=1 for 2 cycles with `ihit`=1 and `branch`=1: IF/ID and PC unchanged. After release, the same address is refetched. `fetch_count` does not advance during the stall.
- `branch`=1, `branch_target`=0x40, `ihit`=1 in the same cycle: next `id_valid`=0 and `imemaddr`=0x40. Repeat with `jump`=1 and `jump_target`=0x80 both set: `jump` wins, giving 0x80.
- `mem_stall`=1 with `halt`=1: no change. Drop `mem_stall`: next edge is HALTED with `imemREN`=0. Further `ihit`/`branch` are ignored until `nRST`.
- Assert `nRST`=0 asynchronously mid-miss at PC 0x24: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end: word type, fetch FSM states,
// the IF/ID pipeline register payload and PC helpers.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Default reset PC for the fetch stage
  localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
  localparam word_t PC_STEP         = 32'd4;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: '0, npc: '0, valid: 1'b0};

  // Instruction addresses are word aligned; drop the byte offset
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter flop.
// Ports: CLK/nRST clock and async active-low reset (to PC_INIT);
//   hold  - keep current value (highest priority)
//   load  - take load_addr (word aligned)
//   inc   - advance by 4, wrapping modulo 2^32
//   pc    - current program counter
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_INIT = PC_INIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              hold,
  input  logic              load,
  input  logic              inc,
  input  logic [WORD_W-1:0] load_addr,
  output logic [WORD_W-1:0] pc
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= align_word(PC_INIT);
    end else if (hold) begin
      pc <= pc;
    end else if (load) begin
      pc <= align_word(load_addr);
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// loads the IF/ID register for decode. Stalls on hazard/mem_stall, redirects
// on branch/jump with a one-bubble squash, and stops for good on halt.
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   ihit, imemload            instruction memory response
//   imemREN, imemaddr         instruction memory request (addr = PC)
//   hazard                    decode stall from hazard unit
//   branch/branch_target      taken branch from decode
//   jump/jump_target          jump from decode (wins over branch)
//   mem_stall                 memory stage stall, freezes the whole stage
//   halt                      stop fetching
//   id_instr/id_npc/id_valid  IF/ID register outputs
//   fetch_count               instructions accepted into IF/ID
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [WORD_W-1:0] PC_INIT = PC_INIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              hazard,
  input  logic              branch,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              jump,
  input  logic [WORD_W-1:0] jump_target,
  input  logic              mem_stall,
  input  logic              halt,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_npc,
  output logic              id_valid,
  output logic [WORD_W-1:0] fetch_count
);

  fetch_state_t      state_q, state_d;
  if_id_t            ifid_q, ifid_d;
  logic [WORD_W-1:0] count_q;
  logic              count_inc;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] redirect_addr;
  logic              pc_hold, pc_load, pc_inc;

  pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
    .CLK       (CLK),
    .nRST      (nRST),
    .hold      (pc_hold),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (redirect_addr),
    .pc        (pc)
  );

  assign pc_plus4      = pc + PC_STEP;
  assign redirect_addr = jump ? jump_target : branch_target;

  // State, IF/ID and counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      ifid_q  <= IF_ID_BUBBLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      if (count_inc) begin
        count_q <= count_q + WORD_W'(1);
      end
    end
  end

  // Next-state and per-edge action selection, in priority order
  always_comb begin
    state_d   = state_q;
    ifid_d    = ifid_q;
    count_inc = 1'b0;
    pc_hold   = 1'b1;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;

    if (state_q == FETCH) begin
      if (mem_stall) begin
        // whole stage frozen
      end else if (halt) begin
        ifid_d  = IF_ID_BUBBLE;
        state_d = HALTED;
      end else if (hazard) begin
        // hold; any word returned now is refetched after the stall
      end else if (jump || branch) begin
        // wrong-path squash: the word at the old PC is dropped
        pc_hold = 1'b0;
        pc_load = 1'b1;
        ifid_d  = IF_ID_BUBBLE;
      end else if (ihit) begin
        pc_hold   = 1'b0;
        pc_inc    = 1'b1;
        ifid_d    = '{instr: imemload, npc: pc_plus4, valid: 1'b1};
        count_inc = 1'b1;
      end else begin
        ifid_d = IF_ID_BUBBLE;
      end
    end else begin
      ifid_d = IF_ID_BUBBLE;
    end
  end

  assign imemREN     = (state_q == FETCH);
  assign imemaddr    = pc;
  assign id_instr    = ifid_q.instr;
  assign id_npc      = ifid_q.npc;
  assign id_valid    = ifid_q.valid;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed per-cycle vectors push the
// expected post-edge outputs; a monitor pops and compares after each edge.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        hazard;
  logic        branch;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        mem_stall;
  logic        halt;
  logic [31:0] id_instr;
  logic [31:0] id_npc;
  logic        id_valid;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [31:0] count;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .hazard        (hazard),
    .branch        (branch),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .mem_stall     (mem_stall),
    .halt          (halt),
    .id_instr      (id_instr),
    .id_npc        (id_npc),
    .id_valid      (id_valid),
    .fetch_count   (fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic r,
                         input logic [31:0] i, input logic [31:0] n,
                         input logic v, input logic [31:0] c);
    chk({tag, ".imemaddr"}, imemaddr, a);
    chk({tag, ".imemREN"}, 32'(imemREN), 32'(r));
    chk({tag, ".id_instr"}, id_instr, i);
    chk({tag, ".id_npc"}, id_npc, n);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(v));
    chk({tag, ".fetch_count"}, fetch_count, c);
  endtask

  // Monitor: compare outputs just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_all(e.tag, e.addr, e.ren, e.instr, e.npc, e.valid, e.count);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic cyc(input string tag,
                     input logic ih, input logic [31:0] word,
                     input logic hz, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt,
                     input logic ms, input logic hl,
                     input logic [31:0] ea, input logic er,
                     input logic [31:0] ei, input logic [31:0] en,
                     input logic ev, input logic [31:0] ec);
    exp_t e;
    @(negedge CLK);
    ihit = ih; imemload = word; hazard = hz;
    branch = br; branch_target = bt; jump = jp; jump_target = jt;
    mem_stall = ms; halt = hl;
    e.addr = ea; e.ren = er; e.instr = ei; e.npc = en;
    e.valid = ev; e.count = ec; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ihit = 0; imemload = '0; hazard = 0; branch = 0; branch_target = '0;
    jump = 0; jump_target = '0; mem_stall = 0; halt = 0;
  endtask

  task automatic drain();
    int budget;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge CLK);
      #2;
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must return before the next edge
  task automatic async_reset(input string tag);
    @(negedge CLK);
    #2;
    idle_inputs();
    nRST = 1'b0;
    #1;
    chk_all(tag, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  localparam logic [31:0] WA = 32'hA000_0001;
  localparam logic [31:0] WB = 32'hB000_0002;
  localparam logic [31:0] WC = 32'hC000_0003;
  localparam logic [31:0] WD = 32'hD000_0004;
  localparam logic [31:0] WW = 32'h1234_5678;
  localparam logic [31:0] WX = 32'h0BAD_F00D;
  localparam logic [31:0] WY = 32'h5555_AAAA;
  localparam logic [31:0] WZ = 32'hCAFE_BABE;

  initial begin
    idle_inputs();
    nRST = 1'b0;
    #3;
    chk_all("reset", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    //        tag         ih word hz br bt          jp jt          ms hl  addr          ren instr npc           v  cnt
    cyc("fetchA",     1, WA, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h04, 1, WA, 32'h04, 1, 32'd1);
    cyc("fetchB",     1, WB, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h08, 1, WB, 32'h08, 1, 32'd2);
    cyc("fetchC",     1, WC, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0C, 1, WC, 32'h0C, 1, 32'd3);
    cyc("fetchD",     1, WD, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h10, 1, WD, 32'h10, 1, 32'd4);
    cyc("miss1",      0, WX, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h10, 1, 0,  32'h0,  0, 32'd4);
    cyc("miss2",      0, WX, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h10, 1, 0,  32'h0,  0, 32'd4);
    cyc("fetchW",     1, WW, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h14, 1, WW, 32'h14, 1, 32'd5);
    cyc("hazard1",    1, WX, 1, 1, 32'h40,    0, 32'h0,     0, 0, 32'h14, 1, WW, 32'h14, 1, 32'd5);
    cyc("hazard2",    1, WX, 1, 1, 32'h40,    0, 32'h0,     0, 0, 32'h14, 1, WW, 32'h14, 1, 32'd5);
    cyc("refetchX",   1, WX, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h18, 1, WX, 32'h18, 1, 32'd6);
    cyc("branch",     1, WY, 0, 1, 32'h40,    0, 32'h0,     0, 0, 32'h40, 1, 0,  32'h0,  0, 32'd6);
    cyc("jump_wins",  1, WY, 0, 1, 32'h40,    1, 32'h80,    0, 0, 32'h80, 1, 0,  32'h0,  0, 32'd6);
    cyc("fetchY",     1, WY, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h84, 1, WY, 32'h84, 1, 32'd7);
    cyc("mstall_hlt", 1, WZ, 1, 1, 32'h40,    1, 32'h80,    1, 1, 32'h84, 1, WY, 32'h84, 1, 32'd7);
    cyc("halt",       1, WZ, 0, 0, 32'h0,     0, 32'h0,     0, 1, 32'h84, 0, 0,  32'h0,  0, 32'd7);
    cyc("halted_br",  1, WZ, 0, 1, 32'h40,    0, 32'h0,     0, 0, 32'h84, 0, 0,  32'h0,  0, 32'd7);
    cyc("halted_jp",  1, WZ, 0, 0, 32'h0,     1, 32'h80,    0, 0, 32'h84, 0, 0,  32'h0,  0, 32'd7);
    drain();
    async_reset("rst_halted");

    // Unaligned target is forced to a word boundary; PC+4 wraps to zero
    cyc("jp_unalign", 0, WX, 0, 0, 32'h0,     1, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h0, 0, 32'd0);
    cyc("wrap",       1, WZ, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,  1, WZ, 32'h0,  1, 32'd1);
    cyc("jp_24",      0, WX, 0, 0, 32'h0,     1, 32'h24,    0, 0, 32'h24, 1, 0,  32'h0,  0, 32'd1);
    cyc("miss_24",    0, WX, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h24, 1, 0,  32'h0,  0, 32'd1);
    drain();
    async_reset("rst_miss");

    cyc("post_rst",   1, WA, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h04, 1, WA, 32'h04, 1, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
